// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS registers at BASE_ADDR with byte strobes,
// read-only hardware-status slots, and SLVERR on unmapped or read-only writes.
module axi_lite_regfile #(
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]     RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
    input  logic                           axi_awvalid,
    output logic                           axi_awready,
    input  logic [DATA_WIDTH-1:0]          axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
    input  logic                           axi_wvalid,
    output logic                           axi_wready,
    output logic [1:0]                     axi_bresp,
    output logic                           axi_bvalid,
    input  logic                           axi_bready,
    input  logic [ADDR_WIDTH-1:0]          axi_araddr,
    input  logic                           axi_arvalid,
    output logic                           axi_arready,
    output logic [DATA_WIDTH-1:0]          axi_rdata,
    output logic [1:0]                     axi_rresp,
    output logic                           axi_rvalid,
    input  logic                           axi_rready,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rd_value,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word index relative to BASE_ADDR; sub-word byte offset bits are dropped.
    function automatic logic [ADDR_WIDTH-1:0] wordOf(input logic [ADDR_WIDTH-1:0] addr);
        return (addr - BASE_ADDR) >> LSB;
    endfunction

    function automatic logic isHit(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= BASE_ADDR) && (wordOf(addr) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    logic                  awFull_q, awFull_d;
    logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
    logic                  wFull_q, wFull_d;
    logic [DATA_WIDTH-1:0] wData_q, wData_d;
    logic [STRB_W-1:0]     wStrb_q, wStrb_d;
    logic                  bValid_q, bValid_d;
    logic [1:0]            bResp_q, bResp_d;
    logic                  rValid_q, rValid_d;
    logic [1:0]            rResp_q, rResp_d;
    logic [DATA_WIDTH-1:0] rData_q, rData_d;
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  awHs, wHs, arHs, commit, wrHit, rdHit;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [DATA_WIDTH-1:0] wrData;
    logic [STRB_W-1:0]     wrStrb;

    assign axi_awready  = !awFull_q && !bValid_q;
    assign axi_wready   = !wFull_q && !bValid_q;
    assign axi_arready  = !rValid_q;
    assign axi_bvalid   = bValid_q;
    assign axi_bresp    = bResp_q;
    assign axi_rvalid   = rValid_q;
    assign axi_rresp    = rResp_q;
    assign axi_rdata    = rData_q;
    assign reg_wr_pulse = pulse_q;

    assign awHs   = axi_awvalid && axi_awready;
    assign wHs    = axi_wvalid && axi_wready;
    assign arHs   = axi_arvalid && axi_arready;
    assign wrAddr = awFull_q ? awAddr_q : axi_awaddr;
    assign wrData = wFull_q ? wData_q : axi_wdata;
    assign wrStrb = wFull_q ? wStrb_q : axi_wstrb;
    assign commit = (awFull_q || awHs) && (wFull_q || wHs);
    assign wrHit  = isHit(wrAddr);
    assign rdHit  = isHit(axi_araddr);

    // Write path: buffer whichever half arrives first, commit once both are present.
    always_comb begin
        awFull_d = awFull_q;
        awAddr_d = awAddr_q;
        wFull_d  = wFull_q;
        wData_d  = wData_q;
        wStrb_d  = wStrb_q;
        bValid_d = bValid_q;
        bResp_d  = bResp_q;
        pulse_d  = '0;
        regs_d   = regs_q;
        if (commit) begin
            awFull_d = 1'b0;
            wFull_d  = 1'b0;
            bValid_d = 1'b1;
            bResp_d  = RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrHit && wordOf(wrAddr) == ADDR_WIDTH'(i) && !RO_MASK[i]) begin
                    bResp_d    = RESP_OKAY;
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wrStrb[b]) begin
                            regs_d[i][8*b +: 8] = wrData[8*b +: 8];
                        end
                    end
                end
            end
        end else begin
            if (awHs) begin
                awFull_d = 1'b1;
                awAddr_d = axi_awaddr;
            end
            if (wHs) begin
                wFull_d = 1'b1;
                wData_d = axi_wdata;
                wStrb_d = axi_wstrb;
            end
            if (bValid_q && axi_bready) begin
                bValid_d = 1'b0;
            end
        end
    end

    // Read path samples regs_q, so a same-edge write commit is not yet visible.
    always_comb begin
        rValid_d = rValid_q;
        rResp_d  = rResp_q;
        rData_d  = rData_q;
        if (arHs) begin
            rValid_d = 1'b1;
            rResp_d  = RESP_SLVERR;
            rData_d  = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rdHit && wordOf(axi_araddr) == ADDR_WIDTH'(i)) begin
                    rResp_d = RESP_OKAY;
                    rData_d = RO_MASK[i] ? hw_rd_value[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
                end
            end
        end else if (rValid_q && axi_rready) begin
            rValid_d = 1'b0;
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awFull_q <= 1'b0;
            awAddr_q <= '0;
            wFull_q  <= 1'b0;
            wData_q  <= '0;
            wStrb_q  <= '0;
            bValid_q <= 1'b0;
            bResp_q  <= RESP_OKAY;
            rValid_q <= 1'b0;
            rResp_q  <= RESP_OKAY;
            rData_q  <= '0;
            pulse_q  <= '0;
            regs_q   <= '{default: RESET_VAL};
        end else begin
            awFull_q <= awFull_d;
            awAddr_q <= awAddr_d;
            wFull_q  <= wFull_d;
            wData_q  <= wData_d;
            wStrb_q  <= wStrb_d;
            bValid_q <= bValid_d;
            bResp_q  <= bResp_d;
            rValid_q <= rValid_d;
            rResp_q  <= rResp_d;
            rData_q  <= rData_d;
            pulse_q  <= pulse_d;
            regs_q   <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed self-checking bench for axi_lite_regfile with BASE 0x1000, register 0
// read-only, and a non-zero reset value so reset effects are observable.
module tb_axi_lite_regfile;

    localparam int          NR      = 8;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [7:0]  RO      = 8'h01;
    localparam logic [31:0] RST_VAL = 32'h0000_5A5A;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    logic         clk;
    logic         rst;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] hwValue, regQ;
    logic [7:0]   pulse;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] expReg [NR];

    axi_lite_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR),
        .BASE_ADDR(BASE), .RO_MASK(RO), .RESET_VAL(RST_VAL)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .hw_rd_value(hwValue), .reg_q(regQ), .reg_wr_pulse(pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] expRegVec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = RO[i] ? 32'h0 : expReg[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic awv, input logic [31:0] awa, input logic wv,
                                 input logic [31:0] wd, input logic [3:0] ws);
        awvalid = awv;
        awaddr  = awa;
        wvalid  = wv;
        wdata   = wd;
        wstrb   = ws;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkRegs(input string tag);
        logic [255:0] expVec;
        expVec = expRegVec();
        assertCount++;
        assert (regQ === expVec) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, regQ, expVec);
        end
    endtask

    // Simultaneous AW/W write; caller updates expReg beforehand for expected successes.
    task automatic writeCheck(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input logic [1:0] expResp, input logic [7:0] expPulse, input string tag);
        applyStimulus(1'b1, addr, 1'b1, data, strb);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        checkOutput({tag, " bvalid"}, 32'(bvalid), 32'd1);
        checkOutput({tag, " bresp"}, 32'(bresp), 32'(expResp));
        checkOutput({tag, " pulse"}, 32'(pulse), 32'(expPulse));
        checkOutput({tag, " awready busy"}, 32'(awready), 32'd0);
        checkRegs({tag, " regs"});
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput({tag, " bvalid clear"}, 32'(bvalid), 32'd0);
        checkOutput({tag, " pulse clear"}, 32'(pulse), 32'd0);
    endtask

    task automatic readCheck(input logic [31:0] addr, input logic [31:0] expData,
                             input logic [1:0] expResp, input string tag);
        arvalid = 1'b1;
        araddr  = addr;
        tick();
        arvalid = 1'b0;
        checkOutput({tag, " rvalid"}, 32'(rvalid), 32'd1);
        checkOutput({tag, " rdata"}, rdata, expData);
        checkOutput({tag, " rresp"}, 32'(rresp), 32'(expResp));
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checkOutput({tag, " rvalid clear"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        hwValue          = '0;
        hwValue[31:0]    = 32'hCAFE_0001;
        hwValue[127:96]  = 32'hFFFF_FFFF;
        for (int i = 0; i < NR; i++) expReg[i] = RST_VAL;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        bready = 1'b0; arvalid = 1'b0; araddr = 32'h0; rready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst bvalid", 32'(bvalid), 32'd0);
        checkOutput("rst rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst bresp", 32'(bresp), 32'd0);
        checkOutput("rst rresp", 32'(rresp), 32'd0);
        checkOutput("rst rdata", rdata, 32'h0);
        checkOutput("rst pulse", 32'(pulse), 32'd0);
        checkOutput("rst ready", {29'h0, awready, wready, arready}, 32'h7);
        checkRegs("rst regs");

        // Simultaneous AW/W to register 1, then read back
        expReg[1] = 32'hDEAD_BEEF;
        writeCheck(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, OKAY, 8'h02, "t1 wr");
        readCheck(BASE + 32'h4, 32'hDEAD_BEEF, OKAY, "t1 rd");

        // W first, AW three cycles later, single byte strobe
        expReg[2] = 32'h1122_3344;
        writeCheck(BASE + 32'h8, 32'h1122_3344, 4'hF, OKAY, 8'h04, "t2 prep");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_00AA, 4'h1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t2 wready buffered", 32'(wready), 32'd0);
        checkOutput("t2 no early b", 32'(bvalid), 32'd0);
        tick();
        tick();
        checkOutput("t2 awready wait", 32'(awready), 32'd1);
        checkOutput("t2 still no b", 32'(bvalid), 32'd0);
        checkRegs("t2 regs before aw");
        applyStimulus(1'b1, BASE + 32'h8, 1'b0, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        expReg[2] = 32'h1122_33AA;
        checkOutput("t2 bvalid", 32'(bvalid), 32'd1);
        checkOutput("t2 bresp", 32'(bresp), 32'(OKAY));
        checkOutput("t2 pulse", 32'(pulse), 32'h04);
        checkRegs("t2 regs");
        tick();
        checkOutput("t2 bvalid held", 32'(bvalid), 32'd1);
        checkOutput("t2 aw/w blocked", {30'h0, awready, wready}, 32'h0);
        checkOutput("t2 pulse one cycle", 32'(pulse), 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        checkOutput("t2 bvalid clear", 32'(bvalid), 32'd0);
        checkOutput("t2 aw/w reopen", {30'h0, awready, wready}, 32'h3);

        // Out-of-range accesses above and below the window; in-range with byte offset
        writeCheck(BASE + 32'h20, 32'h1234_5678, 4'hF, SLVERR, 8'h00, "t3 wr oob");
        readCheck(BASE + 32'h20, 32'h0, SLVERR, "t3 rd oob");
        readCheck(BASE - 32'h4, 32'h0, SLVERR, "t3 rd below");
        readCheck(BASE + 32'h1F, RST_VAL, OKAY, "t3 rd last");

        // Read-only register 0 and a RW register whose hw_rd_value is ignored
        writeCheck(BASE, 32'hFFFF_FFFF, 4'hF, SLVERR, 8'h00, "t4 wr ro");
        readCheck(BASE, 32'hCAFE_0001, OKAY, "t4 rd ro");
        readCheck(BASE + 32'hC, RST_VAL, OKAY, "t4 rd rw");
        checkOutput("t4 ro slice", regQ[31:0], 32'h0);

        // Read stall with rready low; a second AR waits while a write completes
        arvalid = 1'b1;
        araddr  = BASE + 32'h4;
        tick();
        araddr  = BASE + 32'h8;
        checkOutput("t5 rvalid", 32'(rvalid), 32'd1);
        checkOutput("t5 rdata", rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b1, BASE + 32'h14, 1'b1, 32'hA5A5_3C00, 4'h2);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        expReg[5] = 32'h0000_3C5A;
        checkOutput("t5 stall rvalid", 32'(rvalid), 32'd1);
        checkOutput("t5 stall arready", 32'(arready), 32'd0);
        checkOutput("t5 wr bvalid", 32'(bvalid), 32'd1);
        checkOutput("t5 wr pulse", 32'(pulse), 32'h20);
        checkRegs("t5 wr regs");
        bready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t5 stall rvalid", 32'(rvalid), 32'd1);
            checkOutput("t5 stall rdata", rdata, 32'hDEAD_BEEF);
            checkOutput("t5 stall rresp", 32'(rresp), 32'(OKAY));
            checkOutput("t5 stall arready", 32'(arready), 32'd0);
        end
        bready = 1'b0;
        checkOutput("t5 wr done", 32'(bvalid), 32'd0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checkOutput("t5 rvalid clear", 32'(rvalid), 32'd0);
        checkOutput("t5 arready back", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        checkOutput("t5 second rvalid", 32'(rvalid), 32'd1);
        checkOutput("t5 second rdata", rdata, 32'h1122_33AA);
        rready = 1'b1;
        tick();
        rready = 1'b0;

        // Same-edge write commit and read of register 6 returns the old value
        applyStimulus(1'b1, BASE + 32'h18, 1'b1, 32'h7777_7777, 4'hF);
        arvalid = 1'b1;
        araddr  = BASE + 32'h18;
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        arvalid = 1'b0;
        expReg[6] = 32'h7777_7777;
        checkOutput("t6 rdata old", rdata, RST_VAL);
        checkOutput("t6 pulse", 32'(pulse), 32'h40);
        checkRegs("t6 regs");
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;

        // Reset with write response and read data both pending
        applyStimulus(1'b1, BASE + 32'h10, 1'b1, 32'h1234_5678, 4'hF);
        arvalid = 1'b1;
        araddr  = BASE + 32'h4;
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        arvalid = 1'b0;
        checkOutput("t7 pending b", 32'(bvalid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) expReg[i] = RST_VAL;
        checkOutput("t7 bvalid aborted", 32'(bvalid), 32'd0);
        checkOutput("t7 rvalid aborted", 32'(rvalid), 32'd0);
        checkOutput("t7 rdata cleared", rdata, 32'h0);
        checkRegs("t7 regs reset");

        // Buffered W is discarded by reset; a lone AW afterwards must not commit
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h9999_9999, 4'hF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        checkOutput("t8 w buffered", 32'(wready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t8 w buffer flushed", 32'(wready), 32'd1);
        applyStimulus(1'b1, BASE + 32'h4, 1'b0, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        checkOutput("t8 no commit", 32'(bvalid), 32'd0);
        checkOutput("t8 aw buffered", 32'(awready), 32'd0);
        checkRegs("t8 regs untouched");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, 4'hF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        expReg[1] = 32'h0BAD_F00D;
        checkOutput("t8 commit bvalid", 32'(bvalid), 32'd1);
        checkOutput("t8 commit pulse", 32'(pulse), 32'h02);
        checkRegs("t8 regs");
        bready = 1'b1;
        tick();
        bready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
